// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Purpose  : Shared constants for the ROM stream loader: FSM state encoding,
//             default address width, ROM index values and a counter sizing
//             helper.
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Default download address width (16 KiB maximum transfer)
    localparam int unsigned c_DEFAULT_ADDR_W = 14;

    // Well-known target ROM indices on the download bus
    localparam logic [7:0] IDX_PGROM = 8'd0;
    localparam logic [7:0] IDX_CHROM = 8'd1;

    // Loader FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_ACCEPT = 3'd1;
    localparam state_t c_ST_WRITE  = 3'd2;
    localparam state_t c_ST_GAP    = 3'd3;
    localparam state_t c_ST_FINISH = 3'd4;
    localparam state_t c_ST_HOLD   = 3'd5;

    // Width needed to hold (max(a,b) - 1); never less than one bit
    function automatic int unsigned delay_cnt_width(input int unsigned a,
                                                    input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ld_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ld_delay_cnt
//  Purpose  : Loadable down-counter with zero flag. Load has priority over
//             decrement; the count saturates at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ld_delay_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load a new delay, or count down towards zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rom_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_stream_loader
//  Purpose  : Drives the ROM download bus from a valid/ready byte stream.
//             One dn_wr per byte at incrementing addresses from zero, with
//             the CPU held in reset for the transfer plus a settle window.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_stream_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = c_DEFAULT_ADDR_W,
    parameter int unsigned WR_GAP     = 1,
    parameter int unsigned RESET_HOLD = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        start_index,
    input  logic [ADDR_W:0]   start_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic [7:0]        dn_index,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum,
    output logic              cpu_reset
);

    localparam int unsigned       c_CNT_W     = delay_cnt_width(WR_GAP, RESET_HOLD);
    localparam logic [ADDR_W:0]   c_MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    // Counter is loaded with (cycles - 1) so the state lasts exactly 'cycles'
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = (WR_GAP == 0) ? '0 : c_CNT_W'(WR_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = (RESET_HOLD == 0) ? '0 : c_CNT_W'(RESET_HOLD - 1);

    state_t              r_state;
    logic                r_s_ready;
    logic                r_dn_wr;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_dn_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [7:0]          r_dn_data;
    logic [7:0]          r_dn_index;
    logic [7:0]          r_checksum;

    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_wr_last;
    logic [ADDR_W-1:0]   w_last_addr;
    logic                w_cnt_load;
    logic [c_CNT_W-1:0]  w_cnt_load_val;
    logic                w_cnt_dec;
    logic                w_cnt_zero;

    // Oversized lengths clamp to a full address space; since the address
    // equals the byte count, the last address doubles as the end marker.
    assign w_last_addr = (start_len >= c_MAX_LEN) ? {ADDR_W{1'b1}}
                                                  : start_len[ADDR_W-1:0] - ADDR_W'(1);
    assign w_accept    = (r_state == c_ST_ACCEPT) && r_s_ready && s_valid;
    assign w_wr_last   = (r_dn_addr == r_last_addr);

    // Next-state and delay-counter control
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (start_len == '0) ? c_ST_FINISH : c_ST_ACCEPT;
                end
            end
            c_ST_ACCEPT: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                if (w_wr_last) begin
                    w_state_nxt = c_ST_FINISH;
                end else if (WR_GAP == 0) begin
                    w_state_nxt = c_ST_ACCEPT;
                end else begin
                    w_state_nxt    = c_ST_GAP;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_GAP_LOAD;
                end
            end
            c_ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_ACCEPT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            c_ST_FINISH: begin
                if (RESET_HOLD == 0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt    = c_ST_HOLD;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_HOLD_LOAD;
                end
            end
            c_ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Shared timer for the inter-write gap and the post-transfer hold
    ld_delay_cnt #(
        .WIDTH (c_CNT_W)
    ) u_delay_cnt (
        .clk        (clk_sys),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State, registered strobes and download-bus datapath
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_s_ready   <= 1'b0;
            r_dn_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dn_addr   <= '0;
            r_last_addr <= '0;
            r_dn_data   <= '0;
            r_dn_index  <= '0;
            r_checksum  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == c_ST_ACCEPT);
            r_dn_wr   <= (w_state_nxt == c_ST_WRITE);
            r_busy    <= (w_state_nxt == c_ST_ACCEPT) || (w_state_nxt == c_ST_WRITE) ||
                         (w_state_nxt == c_ST_GAP);
            r_done    <= (w_state_nxt == c_ST_FINISH);

            if ((r_state == c_ST_IDLE) && start) begin
                r_dn_index  <= start_index;
                r_last_addr <= w_last_addr;
                r_dn_addr   <= '0;
                r_checksum  <= '0;
            end

            if (w_accept) begin
                r_dn_data <= s_data;
            end

            if (r_state == c_ST_WRITE) begin
                r_checksum <= r_checksum + r_dn_data;
                if (!w_wr_last) begin
                    r_dn_addr <= r_dn_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Strobes are masked by reset so nothing is written or accepted in the
    // reset cycle itself, even if the registers still hold an active value.
    assign s_ready   = r_s_ready & ~reset;
    assign dn_wr     = r_dn_wr & ~reset;
    assign dn_addr   = r_dn_addr;
    assign dn_data   = r_dn_data;
    assign dn_index  = r_dn_index;
    assign busy      = r_busy;
    assign done      = r_done;
    assign checksum  = r_checksum;
    assign cpu_reset = reset | (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/rom_stream_loader.md
Name: rom_stream_loader

Overview:
- Initiator/writer side of the ROM download bus (dn_addr/dn_data/dn_wr/dn_index) consumed by the system top.
- Takes a byte stream with valid/ready handshake plus a start command carrying target index and length.
- Emits one single-cycle dn_wr per byte at incrementing addresses from 0.
- Holds the CPU in reset for the whole transfer and for a settle window afterwards.

Parameters:
- ADDR_W, 14, download address width; maximum transfer is 2^ADDR_W bytes.
- WR_GAP, 1, idle cycles inserted after each dn_wr before the next byte is accepted (0 allowed).
- RESET_HOLD, 16, cycles cpu_reset stays high after the last write (0 allowed).

Ports:
- clk_sys  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command pulse; sampled only in IDLE
- start_index  in  8  target ROM index, latched on accepted start
- start_len  in  ADDR_W+1  byte count; 0 = empty transfer
- s_valid  in  1  source byte valid
- s_data  in  8  source byte
- s_ready  out  1  loader accepts a byte this cycle
- dn_addr  out  ADDR_W  write address
- dn_data  out  8  write data
- dn_wr  out  1  write strobe, exactly one cycle per byte
- dn_index  out  8  target index, stable for the whole transfer
- busy  out  1  transfer in progress (ACCEPT/WRITE/GAP)
- done  out  1  one-cycle pulse at end of transfer
- checksum  out  8  mod-256 sum of all bytes written in the current/last transfer
- cpu_reset  out  1  CPU hold

Behaviour:
- Reset values: s_ready=0, dn_addr=0, dn_data=0, dn_wr=0, dn_index=0, busy=0, done=0, checksum=0, state=IDLE.
- cpu_reset = reset OR (state != IDLE); combinational, so it is 1 during reset.
- States: IDLE, ACCEPT, WRITE, GAP, FINISH, HOLD.
- IDLE:
  - start with start_len != 0: latch index and len, clear dn_addr, byte count and checksum; go to ACCEPT next cycle.
  - start with start_len == 0: go to FINISH; no dn_wr is issued.
- Length clamp: start_len > 2^ADDR_W is clamped to 2^ADDR_W.
- ACCEPT:
  - s_ready=1 (registered; asserted the cycle after entry).
  - On s_valid&&s_ready: register s_data into dn_data and go to WRITE.
  - s_valid low: wait indefinitely.
- WRITE (one cycle):
  - dn_wr=1 with current dn_addr/dn_data; checksum += dn_data.
  - If this byte is the last one (count == len-1): go to FINISH.
  - Otherwise go to GAP, or directly to ACCEPT if WR_GAP=0.
  - dn_addr increments on exit from WRITE except after the last byte; the final dn_addr holds len-1.
- GAP: count WR_GAP cycles with s_ready=0, then go to ACCEPT.
- Throughput: WR_GAP=0 and s_valid held high gives one write every 2 cycles.
- Address wrap: a full 2^ADDR_W transfer ends at addr 2^ADDR_W-1; the address never wraps within a transfer.
- FINISH: done=1 for one cycle; busy=0 from here on; go to HOLD, or to IDLE if RESET_HOLD=0.
- HOLD: count RESET_HOLD cycles, then go to IDLE. cpu_reset falls the cycle IDLE is entered.
- start outside IDLE is ignored; no queuing.
- dn_index, dn_addr, dn_data and checksum hold their values after done until the next accepted start.
- s_ready is never high outside ACCEPT; dn_wr is never high outside WRITE.
- Reset mid-transfer: next cycle state=IDLE, all outputs at reset values, partially written ROM left as is. No dn_wr is issued during or after the reset cycle.

Decomposition:
- Package loader_pkg holds:
  - state enum (IDLE, ACCEPT, WRITE, GAP, FINISH, HOLD);
  - default ADDR_W=14;
  - index constants IDX_PGROM=8'd0, IDX_CHROM=8'd1.
- One sub-module: ld_delay_cnt, a loadable down-counter with zero flag, shared for the GAP and HOLD timing. Everything else inline.

Test Plan:
- start index=1, len=4, bytes 11,22,33,44, s_valid always high, WR_GAP=1 -> dn_wr pulses at addr 0..3 with data 11,22,33,44 and dn_index=1; done once; checksum=0xAA; cpu_reset high until RESET_HOLD=16 cycles after done.
- len=3, s_valid toggled 1-0-0-1, with stalls -> s_ready stays high while waiting; exactly 3 writes, no duplicates; addresses 0,1,2.
- start len=0 -> done pulse 1 cycle after start; no dn_wr; checksum=0; busy never high.
- start len=20000, ADDR_W=14 -> exactly 16384 writes; last at addr 0x3FFF; done after the last write.
- Second start pulsed while busy and while in HOLD -> ignored; the transfer in progress completes unchanged.
- reset asserted after 2 of 5 writes -> next cycle dn_wr=0, s_ready=0, busy=0, checksum=0, state IDLE; cpu_reset follows reset and falls with it. A new start then writes from addr 0.
